// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus arbiter slice.
// Optional feature macro: MEM_ARB_RR_EN (round-robin arbitration in rr_arbiter_2).
package mem_bus_pkg;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 12;
  localparam int WDATA_W   = 6;
  localparam int UPPER_BIT = 6;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    ST_ADDR,
    ST_DATA,
    HALTED
  } state_e;

  typedef enum logic {
    CORE = 1'b0,
    LDR  = 1'b1
  } req_idx_e;

  // Halt signature: read and commit asserted together, which no transfer ever does.
  localparam logic [ADDR_W-1:0] HALT_BUS = '0;
  localparam logic              HALT_RW  = 1'b1;
  localparam logic              HALT_WC  = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester arbiter with a grant-accept input.
// MEM_ARB_RR_EN selects round-robin; otherwise the core wins every tie.
module rr_arbiter_2
  import mem_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       valid,
  output req_idx_e   idx
);

`ifdef MEM_ARB_RR_EN
  // ptr names the requester that wins the next tie; the served one drops behind.
  req_idx_e ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= CORE;
    end else if (accept) begin
      ptr <= (idx == CORE) ? LDR : CORE;
    end
  end

  always_comb begin
    valid = |req;
    idx   = CORE;
    if (req == 2'b11) begin
      idx = ptr;
    end else if (req[1]) begin
      idx = LDR;
    end
  end
`else
  logic unused_ports;
  assign unused_ports = clk ^ rst ^ accept;

  always_comb begin
    valid = |req;
    idx   = CORE;
    if (!req[0] && req[1]) begin
      idx = LDR;
    end
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Sequences the shared memory bus between the CPU core and the loader/debug port.
// Build with MEM_ARB_RR_EN for round-robin arbitration, otherwise fixed core priority.
module mem_bus_arbiter #(
  parameter int ADDR_W  = mem_bus_pkg::ADDR_W,
  parameter int DATA_W  = mem_bus_pkg::DATA_W,
  parameter int WDATA_W = mem_bus_pkg::WDATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               core_req,
  input  logic               core_we,
  input  logic               core_upper,
  input  logic [ADDR_W-1:0]  core_addr,
  input  logic [WDATA_W-1:0] core_wdata,
  output logic               core_gnt,
  output logic               core_done,
  input  logic               ldr_req,
  input  logic               ldr_we,
  input  logic               ldr_upper,
  input  logic [ADDR_W-1:0]  ldr_addr,
  input  logic [WDATA_W-1:0] ldr_wdata,
  output logic               ldr_gnt,
  output logic               ldr_done,
  input  logic               halt_req,
  output logic               halted,
  input  logic [DATA_W-1:0]  mem_in,
  output logic [DATA_W-1:0]  rdata,
  output logic [ADDR_W-1:0]  mem_bus_out,
  output logic               mem_read_write,
  output logic               write_commit
);
  import mem_bus_pkg::*;

  state_e             state, next_state;
  req_idx_e           owner, nxt_owner, arb_idx;
  logic               arb_valid, arb_accept;
  logic               lat_we, lat_upper, nxt_we, nxt_upper;
  logic [ADDR_W-1:0]  lat_addr, nxt_addr, bus_n;
  logic [WDATA_W-1:0] lat_wdata, nxt_wdata;
  logic               rw_n, wc_n, core_gnt_n, ldr_gnt_n, core_done_n, ldr_done_n, halted_n;

  // A requester in its done cycle is still holding req from the finished transfer.
  rr_arbiter_2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({ldr_req & ~ldr_done, core_req & ~core_done}),
    .accept (arb_accept),
    .valid  (arb_valid),
    .idx    (arb_idx)
  );

  always_comb begin
    next_state = state;
    arb_accept = 1'b0;
    nxt_owner  = owner;
    nxt_we     = lat_we;
    nxt_upper  = lat_upper;
    nxt_addr   = lat_addr;
    nxt_wdata  = lat_wdata;
    case (state)
      IDLE: begin
        if (halt_req) begin
          next_state = HALTED;
        end else if (arb_valid) begin
          arb_accept = 1'b1;
          nxt_owner  = arb_idx;
          if (arb_idx == LDR) begin
            nxt_we    = ldr_we;
            nxt_upper = ldr_upper;
            nxt_addr  = ldr_addr;
            nxt_wdata = ldr_wdata;
          end else begin
            nxt_we    = core_we;
            nxt_upper = core_upper;
            nxt_addr  = core_addr;
            nxt_wdata = core_wdata;
          end
          next_state = nxt_we ? ST_ADDR : RD_ADDR;
        end
      end
      RD_ADDR: next_state = RD_DATA;
      RD_DATA: next_state = IDLE;
      ST_ADDR: next_state = ST_DATA;
      ST_DATA: next_state = IDLE;
      HALTED:  next_state = HALTED;
      default: next_state = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they appear registered with it.
  always_comb begin
    bus_n       = '0;
    rw_n        = 1'b1;
    wc_n        = 1'b0;
    core_gnt_n  = 1'b0;
    ldr_gnt_n   = 1'b0;
    core_done_n = 1'b0;
    ldr_done_n  = 1'b0;
    halted_n    = 1'b0;
    case (next_state)
      RD_ADDR, RD_DATA: bus_n = nxt_addr;
      ST_ADDR: begin
        bus_n = nxt_addr;
        rw_n  = 1'b0;
      end
      ST_DATA: begin
        bus_n[WDATA_W-1:0] = nxt_wdata;
        bus_n[UPPER_BIT]   = nxt_upper;
        rw_n               = 1'b0;
        wc_n               = 1'b1;
      end
      HALTED: begin
        bus_n    = ADDR_W'(HALT_BUS);
        rw_n     = HALT_RW;
        wc_n     = HALT_WC;
        halted_n = 1'b1;
      end
      default: ;
    endcase
    if (next_state inside {RD_ADDR, RD_DATA, ST_ADDR, ST_DATA}) begin
      core_gnt_n = (nxt_owner == CORE);
      ldr_gnt_n  = (nxt_owner == LDR);
    end
    if (next_state == IDLE && (state == RD_DATA || state == ST_DATA)) begin
      core_done_n = (owner == CORE);
      ldr_done_n  = (owner == LDR);
    end
  end

  // Async reset clears write_commit at once, so a store cut off mid-commit never lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      owner          <= CORE;
      lat_we         <= 1'b0;
      lat_upper      <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      mem_bus_out    <= '0;
      mem_read_write <= 1'b1;
      write_commit   <= 1'b0;
      core_gnt       <= 1'b0;
      ldr_gnt        <= 1'b0;
      core_done      <= 1'b0;
      ldr_done       <= 1'b0;
      halted         <= 1'b0;
      rdata          <= '0;
    end else begin
      state          <= next_state;
      owner          <= nxt_owner;
      lat_we         <= nxt_we;
      lat_upper      <= nxt_upper;
      lat_addr       <= nxt_addr;
      lat_wdata      <= nxt_wdata;
      mem_bus_out    <= bus_n;
      mem_read_write <= rw_n;
      write_commit   <= wc_n;
      core_gnt       <= core_gnt_n;
      ldr_gnt        <= ldr_gnt_n;
      core_done      <= core_done_n;
      ldr_done       <= ldr_done_n;
      halted         <= halted_n;
      if (state == RD_DATA) begin
        rdata <= mem_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_mem_bus_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  typedef struct packed {
    logic       core_req;
    logic       core_we;
    logic       core_upper;
    logic [9:0] core_addr;
    logic [5:0] core_wdata;
    logic       ldr_req;
    logic       ldr_we;
    logic       ldr_upper;
    logic [9:0] ldr_addr;
    logic [5:0] ldr_wdata;
    logic       halt;
    logic [11:0] mem_in;
  } in_t;

  typedef struct packed {
    logic [9:0]  bus;
    logic        rw;
    logic        wc;
    logic        cg;
    logic        lg;
    logic        cd;
    logic        ld;
    logic        hl;
    logic [11:0] rdata;
  } out_t;

  typedef struct {
    in_t  stim_in;
    out_t exp;
  } vec_t;

  logic        clk;
  logic        rst;
  in_t         stim;
  logic        core_gnt, core_done, ldr_gnt, ldr_done, halted;
  logic        mem_read_write, write_commit;
  logic [11:0] rdata;
  logic [9:0]  mem_bus_out;

  int vectors;
  int miscompares;

  // Reference model state: transaction phase counter rather than an FSM.
  int          m_phase;
  bit          m_halted;
  int          m_owner;
  int          m_done;
  int          m_pref;
  bit          m_we, m_upper;
  logic [9:0]  m_addr;
  logic [5:0]  m_wdata;
  logic [11:0] m_rdata;

  mem_bus_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .core_req       (stim.core_req),
    .core_we        (stim.core_we),
    .core_upper     (stim.core_upper),
    .core_addr      (stim.core_addr),
    .core_wdata     (stim.core_wdata),
    .core_gnt       (core_gnt),
    .core_done      (core_done),
    .ldr_req        (stim.ldr_req),
    .ldr_we         (stim.ldr_we),
    .ldr_upper      (stim.ldr_upper),
    .ldr_addr       (stim.ldr_addr),
    .ldr_wdata      (stim.ldr_wdata),
    .ldr_gnt        (ldr_gnt),
    .ldr_done       (ldr_done),
    .halt_req       (stim.halt),
    .halted         (halted),
    .mem_in         (stim.mem_in),
    .rdata          (rdata),
    .mem_bus_out    (mem_bus_out),
    .mem_read_write (mem_read_write),
    .write_commit   (write_commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mkIn(bit cr, bit cw, bit cu, logic [9:0] ca, logic [5:0] cdat,
                               bit lr, bit lw, bit lu, logic [9:0] la, logic [5:0] ldat,
                               bit h, logic [11:0] mi);
    in_t s;
    s.core_req = cr;  s.core_we = cw;  s.core_upper = cu;  s.core_addr = ca;  s.core_wdata = cdat;
    s.ldr_req  = lr;  s.ldr_we  = lw;  s.ldr_upper  = lu;  s.ldr_addr  = la;  s.ldr_wdata  = ldat;
    s.halt = h;  s.mem_in = mi;
    return s;
  endfunction

  function automatic out_t mkOut(logic [9:0] bus, bit rw, bit wc, bit cg, bit lg,
                                 bit cd, bit ld, bit hl, logic [11:0] rd);
    out_t o;
    o.bus = bus;  o.rw = rw;  o.wc = wc;  o.cg = cg;  o.lg = lg;
    o.cd = cd;  o.ld = ld;  o.hl = hl;  o.rdata = rd;
    return o;
  endfunction

  task automatic modelReset();
    m_phase = 0;  m_halted = 0;  m_owner = 0;  m_done = -1;  m_pref = 0;
    m_we = 0;  m_upper = 0;  m_addr = '0;  m_wdata = '0;  m_rdata = '0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic modelStep();
    int  nd;
    int  win;
    bit  c, l;
    nd = -1;
    if (!m_halted) begin
      case (m_phase)
        0: begin
          if (stim.halt) begin
            m_halted = 1;
          end else begin
            c = stim.core_req && (m_done != 0);
            l = stim.ldr_req && (m_done != 1);
            if (c || l) begin
              if (c && l) win = RR_MODE ? m_pref : 0;
              else        win = c ? 0 : 1;
              m_pref  = 1 - win;
              m_owner = win;
              m_we    = win ? stim.ldr_we    : stim.core_we;
              m_upper = win ? stim.ldr_upper : stim.core_upper;
              m_addr  = win ? stim.ldr_addr  : stim.core_addr;
              m_wdata = win ? stim.ldr_wdata : stim.core_wdata;
              m_phase = 1;
            end
          end
        end
        1: m_phase = 2;
        default: begin
          if (!m_we) m_rdata = stim.mem_in;
          m_phase = 0;
          nd = m_owner;
        end
      endcase
    end
    m_done = nd;
  endtask

  function automatic out_t modelOut();
    out_t o;
    o = mkOut(10'h000, 1, 0, 0, 0, 0, 0, 0, m_rdata);
    if (m_halted) begin
      o.wc = 1;
      o.hl = 1;
    end else if (m_phase != 0) begin
      o.rw  = !m_we;
      o.wc  = m_we && (m_phase == 2);
      o.bus = (m_we && m_phase == 2) ? {3'b000, m_upper, m_wdata} : m_addr;
      o.cg  = (m_owner == 0);
      o.lg  = (m_owner == 1);
    end
    if (m_done == 0) o.cd = 1;
    if (m_done == 1) o.ld = 1;
    return o;
  endfunction

  task automatic checkOutput(input string name, input out_t exp);
    out_t act;
    act = mkOut(mem_bus_out, mem_read_write, write_commit, core_gnt, ldr_gnt,
                core_done, ldr_done, halted, rdata);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got bus=%h rw=%b wc=%b cg=%b lg=%b cd=%b ld=%b halted=%b rdata=%h, want bus=%h rw=%b wc=%b cg=%b lg=%b cd=%b ld=%b halted=%b rdata=%h",
               name, act.bus, act.rw, act.wc, act.cg, act.lg, act.cd, act.ld, act.hl, act.rdata,
               exp.bus, exp.rw, exp.wc, exp.cg, exp.lg, exp.cd, exp.ld, exp.hl, exp.rdata);
    end
  endtask

  // Called at a negedge: drive inputs, step the model, land on the next negedge.
  task automatic applyStimulus(input in_t s);
    stim = s;
    modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic resetPulse();
    rst  = 1'b1;
    stim = '0;
    modelReset();
    @(negedge clk);
    checkOutput("reset_state", mkOut(10'h000, 1, 0, 0, 0, 0, 0, 0, 12'h000));
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        tbl[17];
    in_t         none, both, tie, cst, lst, crd;
    logic [9:0]  tie_bus;
    bit          tie_ldr;

    vectors     = 0;
    miscompares = 0;
    none = mkIn(0,0,0,10'h000,6'h00, 0,0,0,10'h000,6'h00, 0,12'h000);
    both = mkIn(1,0,0,10'h3FF,6'h00, 1,0,0,10'h001,6'h00, 0,12'h000);
    lst  = mkIn(0,0,0,10'h000,6'h00, 1,1,1,10'h020,6'h2A, 0,12'h000);
    crd  = mkIn(1,0,0,10'h155,6'h00, 0,0,0,10'h000,6'h00, 0,12'h000);

    tbl[0]  = '{crd, mkOut(10'h155, 1, 0, 1, 0, 0, 0, 0, 12'h000)};
    tbl[1]  = '{crd, mkOut(10'h155, 1, 0, 1, 0, 0, 0, 0, 12'h000)};
    tbl[2]  = '{crd, mkOut(10'h000, 1, 0, 0, 0, 1, 0, 0, 12'hABC)};
    tbl[2].stim_in.mem_in = 12'hABC;
    tbl[3]  = '{lst, mkOut(10'h020, 0, 0, 0, 1, 0, 0, 0, 12'hABC)};
    tbl[4]  = '{lst, mkOut(10'h06A, 0, 1, 0, 1, 0, 0, 0, 12'hABC)};
    tbl[5]  = '{lst, mkOut(10'h000, 1, 0, 0, 0, 0, 1, 0, 12'hABC)};
    tbl[6]  = '{none, mkOut(10'h000, 1, 0, 0, 0, 0, 0, 0, 12'hABC)};
    tbl[7]  = '{both, mkOut(10'h3FF, 1, 0, 1, 0, 0, 0, 0, 12'hABC)};
    tbl[8]  = '{both, mkOut(10'h3FF, 1, 0, 1, 0, 0, 0, 0, 12'hABC)};
    tbl[9]  = '{both, mkOut(10'h000, 1, 0, 0, 0, 1, 0, 0, 12'h123)};
    tbl[9].stim_in.mem_in = 12'h123;
    tbl[10] = '{both, mkOut(10'h001, 1, 0, 0, 1, 0, 0, 0, 12'h123)};
    tbl[11] = '{both, mkOut(10'h001, 1, 0, 0, 1, 0, 0, 0, 12'h123)};
    tbl[12] = '{both, mkOut(10'h000, 1, 0, 0, 0, 0, 1, 0, 12'h456)};
    tbl[12].stim_in.mem_in = 12'h456;
    tbl[13] = '{both, mkOut(10'h3FF, 1, 0, 1, 0, 0, 0, 0, 12'h456)};
    tbl[14] = '{both, mkOut(10'h3FF, 1, 0, 1, 0, 0, 0, 0, 12'h456)};
    tbl[15] = '{none, mkOut(10'h000, 1, 0, 0, 0, 1, 0, 0, 12'h789)};
    tbl[15].stim_in.mem_in = 12'h789;
    tbl[16] = '{none, mkOut(10'h000, 1, 0, 0, 0, 0, 0, 0, 12'h789)};

    rst  = 1'b1;
    stim = '0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_state", mkOut(10'h000, 1, 0, 0, 0, 0, 0, 0, 12'h000));
    rst = 1'b0;

    $display("[TB] directed vector table");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(tbl[i].stim_in);
      checkOutput($sformatf("table_%0d", i), tbl[i].exp);
    end

    // Fresh tie with no done pending; round-robin owes the loader after the core's last grant.
    tie     = mkIn(1,0,0,10'h111,6'h00, 1,0,0,10'h222,6'h00, 0,12'h000);
    tie_ldr = RR_MODE;
    tie_bus = tie_ldr ? 10'h222 : 10'h111;
    applyStimulus(tie);
    checkOutput("tie_grant", mkOut(tie_bus, 1, 0, !tie_ldr, tie_ldr, 0, 0, 0, 12'h789));
    applyStimulus(none);
    stim.mem_in = 12'h0F0;
    applyStimulus(stim);
    checkOutput("tie_done", mkOut(10'h000, 1, 0, 0, 0, !tie_ldr, tie_ldr, 0, 12'h0F0));
    applyStimulus(none);

    $display("[TB] halt raised during a store");
    cst = mkIn(1,1,0,10'h0AA,6'h15, 0,0,0,10'h000,6'h00, 0,12'h000);
    applyStimulus(cst);
    checkOutput("halt_st_addr", mkOut(10'h0AA, 0, 0, 1, 0, 0, 0, 0, 12'h0F0));
    cst.halt = 1'b1;
    applyStimulus(cst);
    checkOutput("halt_st_data", mkOut(10'h015, 0, 1, 1, 0, 0, 0, 0, 12'h0F0));
    applyStimulus(cst);
    checkOutput("halt_st_done", mkOut(10'h000, 1, 0, 0, 0, 1, 0, 0, 12'h0F0));
    cst.ldr_req = 1'b1;
    applyStimulus(cst);
    checkOutput("halt_enter", mkOut(10'h000, 1, 1, 0, 0, 0, 0, 1, 12'h0F0));
    cst.halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(cst);
      checkOutput($sformatf("halt_absorb_%0d", i), mkOut(10'h000, 1, 1, 0, 0, 0, 0, 1, 12'h0F0));
    end

    $display("[TB] reset during store commit");
    resetPulse();
    applyStimulus(mkIn(0,0,0,10'h000,6'h00, 1,1,1,10'h03C,6'h3F, 0,12'h000));
    checkOutput("rst_st_addr", mkOut(10'h03C, 0, 0, 0, 1, 0, 0, 0, 12'h000));
    applyStimulus(stim);
    checkOutput("rst_st_data", mkOut(10'h07F, 0, 1, 0, 1, 0, 0, 0, 12'h000));
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("rst_async", mkOut(10'h000, 1, 0, 0, 0, 0, 0, 0, 12'h000));
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(mkIn(1,0,0,10'h2B4,6'h00, 0,0,0,10'h000,6'h00, 0,12'h000));
    checkOutput("rst_rd_addr", mkOut(10'h2B4, 1, 0, 1, 0, 0, 0, 0, 12'h000));
    applyStimulus(stim);
    stim.mem_in = 12'h5A5;
    applyStimulus(stim);
    checkOutput("rst_rd_done", mkOut(10'h000, 1, 0, 0, 0, 1, 0, 0, 12'h5A5));

    $display("[TB] randomized traffic against reference model");
    resetPulse();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        resetPulse();
      end else begin
        in_t r;
        r = mkIn($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 10'($urandom), 6'($urandom),
                 $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 10'($urandom), 6'($urandom),
                 $urandom_range(0, 79) == 0, 12'($urandom));
        applyStimulus(r);
        checkOutput($sformatf("random_%0d", i), modelOut());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
